// File: rtl/led_fade_sched_if.sv
// LED bank bus: run enable in, PWM pins / base level / period marker out.
// Purely structural; no state and no latency of its own.
// No backpressure: the producer side drives outputs every cycle.
`timescale 1ns/1ps
interface led_fade_sched_if;
  logic        en;
  logic [15:0] LED;
  logic [7:0]  duty;
  logic        period_start;

  modport master (output en, input LED, input duty, input period_start);
  modport slave  (input en, output LED, output duty, output period_start);
endinterface

// File: rtl/led_fade_sched.sv
// Sixteen-lane breathing/chase PWM scheduler sharing one prescaler and period counter.
// LED is registered one sys_clk after pwm_cnt/base; duty is base itself; period_start follows the boundary by one edge.
// No backpressure: en=0 synchronously parks everything in IDLE with outputs low.
`timescale 1ns/1ps
module led_fade_sched #(
  parameter int unsigned N     = 1000,
  parameter int unsigned STEP  = 1,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned PHASE = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  led_fade_sched_if.slave   bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [2:0] {IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      pwm_q, pwm_d;
  logic [7:0]      base_q, base_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [15:0]     led_q, led_d;
  logic            pstart_q, pstart_d;

  logic            run;
  logic            tick;
  logic            boundary;
  logic [7:0]      lane_duty [16];
  logic [7:0]      down_val;
  logic [7:0]      up_val;

  // Counters only advance while enabled and out of IDLE.
  assign run      = bus.en && (state_q != IDLE);
  assign tick     = run && (presc_q == PW'(N - 1));
  assign boundary = tick && (pwm_q == 8'hFF);

  // Saturating one-step moves of the base level.
  assign down_val = ({1'b0, base_q} <= 9'(STEP)) ? 8'd0 : (base_q - 8'(STEP));
  assign up_val   = (({1'b0, base_q} + 9'(STEP)) >= 9'd255) ? 8'hFF : (base_q + 8'(STEP));

  // Each lane is offset from the base level by its index times PHASE, 8-bit wrap.
  for (genvar g = 0; g < 16; g++) begin : g_lane
    assign lane_duty[g] = base_q + 8'((g * PHASE) % 256);
  end

  // Prescaler and PWM period counter; both restart from zero whenever not running.
  always_comb begin
    presc_d = presc_q;
    pwm_d   = pwm_q;
    if (!run) begin
      presc_d = '0;
      pwm_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      pwm_d   = pwm_q + 8'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Level sequencer: only boundaries move it, except entering/leaving IDLE.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    hold_d  = hold_q;
    if (!bus.en) begin
      state_d = IDLE;
      base_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
          base_d  = '0;
          hold_d  = '0;
        end
        RAMP_UP: begin
          if (boundary) begin
            base_d = up_val;
            if (up_val == 8'hFF) begin
              hold_d  = '0;
              state_d = HOLD_HI;
            end
          end
        end
        HOLD_HI: begin
          if (boundary) begin
            if (hold_q == HW'(HOLD - 1)) begin
              hold_d  = '0;
              base_d  = down_val;
              state_d = (down_val == 8'd0) ? HOLD_LO : RAMP_DOWN;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        RAMP_DOWN: begin
          if (boundary) begin
            base_d = down_val;
            if (down_val == 8'd0) begin
              hold_d  = '0;
              state_d = HOLD_LO;
            end
          end
        end
        HOLD_LO: begin
          if (boundary) begin
            if (hold_q == HW'(HOLD - 1)) begin
              hold_d  = '0;
              base_d  = up_val;
              state_d = RAMP_UP;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          base_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Per-lane PWM compare and period marker, forced low unless running.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < 16; i++) begin
      led_d[i] = run && (pwm_q < lane_duty[i]);
    end
    pstart_d = boundary;
  end

  // State register with asynchronous reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      pwm_q    <= '0;
      base_q   <= '0;
      hold_q   <= '0;
      led_q    <= '0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      base_q   <= base_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
      pstart_q <= pstart_d;
    end
  end

  assign bus.LED          = led_q;
  assign bus.duty         = base_q;
  assign bus.period_start = pstart_q;

endmodule

// File: tb/tb_led_fade_sched.sv
// Bench for led_fade_sched: three parameterisations share clock, reset and enable.
// A timeline model (edges since leaving IDLE) plus a precomputed level list predicts every output.
// Directed literals pin the level lists, lane duties and pulse counts.
`timescale 1ns/1ps
module tb_led_fade_sched;

  logic sys_clk = 1'b0;
  logic rst;
  logic en;

  always #5 sys_clk = ~sys_clk;

  led_fade_sched_if ifa ();
  led_fade_sched_if ifb ();
  led_fade_sched_if ifc ();

  assign ifa.en = en;
  assign ifb.en = en;
  assign ifc.en = en;

  led_fade_sched #(.N(4), .STEP(64),  .HOLD(2), .PHASE(16)) dut_a (.sys_clk(sys_clk), .rst(rst), .bus(ifa));
  led_fade_sched #(.N(1), .STEP(100), .HOLD(1), .PHASE(16)) dut_b (.sys_clk(sys_clk), .rst(rst), .bus(ifb));
  led_fade_sched #(.N(1), .STEP(255), .HOLD(1), .PHASE(16)) dut_c (.sys_clk(sys_clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  int n_of    [3] = '{4, 1, 1};
  int step_of [3] = '{64, 100, 255};
  int hold_of [3] = '{2, 1, 1};
  int seq [3][64];

  int lit_a [12] = '{0, 64, 128, 192, 255, 255, 191, 127, 63, 0, 0, 64};
  int lit_b [8]  = '{0, 100, 200, 255, 155, 55, 0, 100};
  int lit_c [4]  = '{0, 255, 0, 255};

  // Timeline model: run = DUT out of IDLE, t = edges since it left IDLE.
  logic run = 1'b0;
  int   t   = 0;

  always @(posedge sys_clk) begin
    if (rst || !en) begin
      run <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
      t   <= 0;
    end else begin
      t <= t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Per-period base levels: initial climb from 0, then hold-high, descent, hold-low, climb from STEP.
  task automatic build_seq(input int k);
    int q[$];
    int st;
    int h;
    st = step_of[k];
    h  = hold_of[k];
    q.push_back(0);
    for (int v = st; v < 255; v += st) q.push_back(v);
    while (q.size() < 64) begin
      repeat (h) q.push_back(255);
      for (int v = 255 - st; v > 0; v -= st) q.push_back(v);
      repeat (h) q.push_back(0);
      q.push_back(st);
      for (int v = 2 * st; v < 255; v += st) q.push_back(v);
    end
    for (int i = 0; i < 64; i++) seq[k][i] = q[i];
  endtask

  function automatic int base_at(input int k, input int s);
    int p;
    p = s / (256 * n_of[k]);
    if (p > 63) p = 63;
    return seq[k][p];
  endfunction

  function automatic logic [15:0] led_at(input int k, input int s);
    logic [15:0] r;
    int pwm;
    int b;
    pwm = (s / n_of[k]) % 256;
    b   = base_at(k, s);
    for (int i = 0; i < 16; i++) r[i] = (pwm < ((b + i * 16) % 256));
    return r;
  endfunction

  logic [15:0] act_led [3];
  logic [7:0]  act_duty [3];
  logic        act_ps [3];
  assign act_led[0] = ifa.LED;  assign act_duty[0] = ifa.duty;  assign act_ps[0] = ifa.period_start;
  assign act_led[1] = ifb.LED;  assign act_duty[1] = ifb.duty;  assign act_ps[1] = ifb.period_start;
  assign act_led[2] = ifc.LED;  assign act_duty[2] = ifc.duty;  assign act_ps[2] = ifc.period_start;

  // Every falling edge: all three instances against the model.
  always @(negedge sys_clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [15:0] e_led;
      logic [7:0]  e_duty;
      logic        e_ps;
      e_led  = '0;
      e_duty = '0;
      e_ps   = 1'b0;
      if (!rst && run) begin
        e_duty = 8'(base_at(k, t));
        e_ps   = (t > 0) && (t % (256 * n_of[k]) == 0);
        if (t > 0) e_led = led_at(k, t - 1);
      end
      check($sformatf("led[%0d]", k),  act_led[k],  e_led);
      check($sformatf("duty[%0d]", k), act_duty[k], e_duty);
      check($sformatf("pstart[%0d]", k), act_ps[k], e_ps);
    end
  end

  int cnt0, cnt12, cnt15, ps_a, ps_b;

  initial begin
    for (int k = 0; k < 3; k++) build_seq(k);
    en  = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_led",    ifa.LED, 0);
    check("reset_duty",   ifa.duty, 0);
    check("reset_pstart", ifa.period_start, 0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;

    // Run into the third period of A (base 128, still climbing), then drop en.
    @(negedge sys_clk);
    en = 1'b1;
    repeat (2501) @(negedge sys_clk);
    check("a_duty_before_drop", ifa.duty, 128);
    check("b_duty_before_drop", ifb.duty, 255);
    en = 1'b0;
    @(posedge sys_clk);
    #1;
    check("drop_led_a",  ifa.LED, 0);
    check("drop_duty_a", ifa.duty, 0);
    check("drop_duty_b", ifb.duty, 0);

    // Restart, then hit asynchronous reset mid-period.
    repeat (5) @(negedge sys_clk);
    en = 1'b1;
    repeat (701) @(negedge sys_clk);
    check("b_duty_restart", ifb.duty, 200);
    @(posedge sys_clk);
    #2 rst = 1'b1;
    #1;
    check("arst_led_a",    ifa.LED, 0);
    check("arst_duty_b",   ifb.duty, 0);
    check("arst_led_b",    ifb.LED, 0);
    check("arst_pstart_a", ifa.period_start, 0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;

    // Long run with en held high.
    cnt0 = 0; cnt12 = 0; cnt15 = 0; ps_a = 0; ps_b = 0;
    repeat (12 * 1024 + 20) begin
      @(negedge sys_clk);
      if (run) begin
        if (t % 1024 == 512 && t / 1024 < 12) check($sformatf("a_seq[%0d]", t / 1024), ifa.duty, lit_a[t / 1024]);
        if (t % 256 == 128 && t / 256 < 8)    check($sformatf("b_seq[%0d]", t / 256), ifb.duty, lit_b[t / 256]);
        if (t % 256 == 128 && t / 256 < 4)    check($sformatf("c_seq[%0d]", t / 256), ifc.duty, lit_c[t / 256]);
        if (t >= 1025 && t <= 2048) begin
          cnt0  += int'(ifa.LED[0]);
          cnt12 += int'(ifa.LED[12]);
          cnt15 += int'(ifa.LED[15]);
        end
        if (t == 2048) begin
          check("a_lane0_high",  cnt0, 256);
          check("a_lane15_high", cnt15, 192);
          check("a_lane12_high", cnt12, 0);
        end
      end
      ps_a += int'(ifa.period_start);
      ps_b += int'(ifb.period_start);
    end
    check("a_pstart_count", ps_a, 12);
    check("b_pstart_count", ps_b, 48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
